// File: rtl/nn_frame_sequencer.sv
// nn_frame_sequencer: streams N_IN bytes into a network, starts it, waits for done (with timeout), streams N_OUT result bytes out
module nn_frame_sequencer #(
  parameter int N_IN = 1,
  parameter int N_OUT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [8*N_IN-1:0]    nn_in,
  output logic                 nn_start,
  input  logic                 nn_done,
  input  logic [8*N_OUT-1:0]   nn_out,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, WAIT = 2'd2, UNLOAD = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic [JW-1:0] j;
  logic [CW-1:0] cnt;
  logic [8*N_OUT-1:0] res;
  logic last_in, last_out, tmo;
  assign last_in = idx == IW'(N_IN - 1);
  assign last_out = j == JW'(N_OUT - 1);
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign s_ready = state == LOAD;
  assign m_valid = state == UNLOAD;
  assign m_last = m_valid && last_out;
  assign busy = state != LOAD;
  always_comb begin
    m_data = '0;
    for (int k = 0; k < N_OUT; k++)
      m_data = int'(j) == k ? res[8*k +: 8] : m_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      idx <= '0;
      j <= '0;
      cnt <= '0;
      nn_in <= '0;
      res <= '0;
      nn_start <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LOAD: if (s_valid) begin
          for (int k = 0; k < N_IN; k++)
            if (int'(idx) == k) nn_in[8*k +: 8] <= s_data;
          timeout_err <= 1'b0;
          idx <= last_in ? '0 : idx + 1'b1;
          if (last_in) begin
            state <= START;
            nn_start <= 1'b1;
          end
        end
        START: begin
          nn_start <= 1'b0;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done beats a coincident timeout
          if (nn_done) begin
            res <= nn_out;
            cnt <= '0;
            state <= UNLOAD;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            cnt <= '0;
            state <= LOAD;
          end else cnt <= cnt + 1'b1;
        end
        default: if (m_ready) begin
          j <= last_out ? '0 : j + 1'b1;
          if (last_out) state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nn_frame_sequencer.sv
// tb_nn_frame_sequencer: directed self-checking bench for a 1-in/1-out and a 4-in/2-out sequencer
module tb_nn_frame_sequencer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic [7:0] a_s_data = 0, a_m_data, a_nn_in, a_nn_out = 0;
  logic a_s_valid = 0, a_s_ready, a_nn_start, a_nn_done = 0, a_m_valid, a_m_ready = 0, a_m_last, a_busy, a_terr;
  logic [7:0] b_s_data = 0, b_m_data;
  logic [31:0] b_nn_in;
  logic [15:0] b_nn_out = 0;
  logic b_s_valid = 0, b_s_ready, b_nn_start, b_nn_done = 0, b_m_valid, b_m_ready = 0, b_m_last, b_busy, b_terr;

  nn_frame_sequencer #(.N_IN(1), .N_OUT(1), .TIMEOUT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .nn_in(a_nn_in), .nn_start(a_nn_start), .nn_done(a_nn_done), .nn_out(a_nn_out),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_last(a_m_last),
    .busy(a_busy), .timeout_err(a_terr));

  nn_frame_sequencer #(.N_IN(4), .N_OUT(2), .TIMEOUT(8)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .nn_in(b_nn_in), .nn_start(b_nn_start), .nn_done(b_nn_done), .nn_out(b_nn_out),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .busy(b_busy), .timeout_err(b_terr));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      b_s_data = w[8*k +: 8];
      b_s_valid = 1;
      tick;
    end
    b_s_valid = 0;
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_s_ready"}, b_s_ready, 1);
    chk({tag, "_m_valid"}, b_m_valid, 0);
    chk({tag, "_m_last"}, b_m_last, 0);
    chk({tag, "_busy"}, b_busy, 0);
    chk({tag, "_nn_in"}, b_nn_in, 0);
    chk({tag, "_nn_start"}, b_nn_start, 0);
    chk({tag, "_terr"}, b_terr, 0);
  endtask

  initial begin
    #1;
    chk_reset_b("rst_b");
    chk("rst_a_s_ready", a_s_ready, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_nn_in", a_nn_in, 0);
    tick;
    tick;
    rst_n = 1;

    // single byte frame, done three cycles after start
    a_s_data = 8'h5A;
    a_s_valid = 1;
    a_nn_out = 8'hC3;
    tick;
    a_s_valid = 0;
    chk("a_nn_in", a_nn_in, 8'h5A);
    chk("a_start_hi", a_nn_start, 1);
    chk("a_start_sready", a_s_ready, 0);
    chk("a_start_busy", a_busy, 1);
    tick;
    chk("a_start_lo", a_nn_start, 0);
    tick;
    tick;
    chk("a_wait_start_lo", a_nn_start, 0);
    a_nn_done = 1;
    tick;
    a_nn_done = 0;
    chk("a_m_valid", a_m_valid, 1);
    chk("a_m_data", a_m_data, 8'hC3);
    chk("a_m_last", a_m_last, 1);
    a_m_ready = 1;
    tick;
    a_m_ready = 0;
    chk("a_end_m_valid", a_m_valid, 0);
    chk("a_end_s_ready", a_s_ready, 1);

    // four byte frame with gaps between beats
    for (int i = 0; i < 4; i++) begin
      b_s_data = 8'(i + 1);
      b_s_valid = 1;
      tick;
      b_s_valid = 0;
      chk("b_start_timing", b_nn_start, i == 3);
      if (i < 3) tick;
    end
    chk("b_nn_in", b_nn_in, 32'h04030201);
    chk("b_start_sready", b_s_ready, 0);
    b_s_data = 8'hFF;
    b_s_valid = 1;
    tick;
    chk("b_wait_nn_in_hold", b_nn_in, 32'h04030201);
    chk("b_wait_sready", b_s_ready, 0);
    b_s_valid = 0;
    b_nn_out = 16'hBBAA;
    b_nn_done = 1;
    tick;
    b_nn_done = 0;
    b_nn_out = 16'h0000;
    chk("b_u0_valid", b_m_valid, 1);
    chk("b_u0_data", b_m_data, 8'hAA);
    chk("b_u0_last", b_m_last, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("b_stall_valid", b_m_valid, 1);
      chk("b_stall_data", b_m_data, 8'hAA);
      chk("b_stall_last", b_m_last, 0);
    end
    b_m_ready = 1;
    tick;
    chk("b_u1_data", b_m_data, 8'hBB);
    chk("b_u1_last", b_m_last, 1);
    tick;
    b_m_ready = 0;
    chk("b_end_valid", b_m_valid, 0);
    chk("b_end_sready", b_s_ready, 1);
    chk("b_end_nn_in", b_nn_in, 32'h04030201);

    // timeout after 8 WAIT cycles
    a_s_data = 8'h11;
    a_s_valid = 1;
    tick;
    a_s_valid = 0;
    tick;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("a_to_pending_terr", a_terr, 0);
      chk("a_to_pending_busy", a_busy, 1);
    end
    tick;
    chk("a_to_terr", a_terr, 1);
    chk("a_to_sready", a_s_ready, 1);
    chk("a_to_m_valid", a_m_valid, 0);
    tick;
    chk("a_to_sticky", a_terr, 1);
    chk("a_to_m_valid2", a_m_valid, 0);
    a_s_data = 8'h22;
    a_s_valid = 1;
    tick;
    a_s_valid = 0;
    chk("a_to_clear", a_terr, 0);
    chk("a_to_restart", a_nn_start, 1);

    // done on the 8th WAIT cycle wins over timeout
    tick;
    a_nn_out = 8'h77;
    for (int i = 0; i < 7; i++) tick;
    a_nn_done = 1;
    tick;
    a_nn_done = 0;
    chk("a_late_terr", a_terr, 0);
    chk("a_late_valid", a_m_valid, 1);
    chk("a_late_data", a_m_data, 8'h77);
    a_m_ready = 1;
    tick;
    a_m_ready = 0;
    chk("a_late_done", a_s_ready, 1);

    // reset in WAIT
    load_b(32'h44332211);
    tick;
    chk("b_pre_rst_busy", b_busy, 1);
    rst_n = 0;
    #1;
    chk_reset_b("rst_wait");
    chk("rst_wait_a_ready", a_s_ready, 1);
    #2;
    rst_n = 1;
    tick;
    tick;
    chk("b_post_rst_start", b_nn_start, 0);
    chk("b_post_rst_valid", b_m_valid, 0);

    // reset in UNLOAD
    load_b(32'h88776655);
    tick;
    b_nn_out = 16'hDDCC;
    b_nn_done = 1;
    tick;
    b_nn_done = 0;
    chk("b_pre_rst_valid", b_m_valid, 1);
    rst_n = 0;
    #1;
    chk_reset_b("rst_unload");
    #2;
    rst_n = 1;
    tick;
    tick;
    chk("b_post_rst2_valid", b_m_valid, 0);
    chk("b_post_rst2_start", b_nn_start, 0);

    // fresh frame after reset
    load_b(32'h0D0C0B0A);
    chk("b_fresh_nn_in", b_nn_in, 32'h0D0C0B0A);
    chk("b_fresh_start", b_nn_start, 1);
    tick;
    b_nn_out = 16'hFFEE;
    b_nn_done = 1;
    tick;
    b_nn_done = 0;
    b_m_ready = 1;
    chk("b_fresh_d0", b_m_data, 8'hEE);
    chk("b_fresh_l0", b_m_last, 0);
    tick;
    chk("b_fresh_d1", b_m_data, 8'hFF);
    chk("b_fresh_l1", b_m_last, 1);
    tick;
    b_m_ready = 0;
    chk("b_fresh_end", b_s_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_frame_sequencer.md
NN_FRAME_SEQUENCER -- requirements
Module: nn_frame_sequencer

Interface
REQ-001 Parameters, one per line: N_IN, 1, number of 8-bit network input bytes per frame.
REQ-002 N_OUT, 1, number of 8-bit network result bytes per frame.
REQ-003 TIMEOUT, 64, maximum cycles in WAIT before abort; range 2..65535.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 s_data  in  8  input byte stream data.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  sequencer accepts s_data this cycle.
REQ-009 nn_in  out  8*N_IN  network input vector; byte k on bits [8k+7:8k].
REQ-010 nn_start  out  1  one-cycle start pulse to the network.
REQ-011 nn_done  in  1  network done level, sampled in WAIT only.
REQ-012 nn_out  in  8*N_OUT  network result vector; byte j on bits [8j+7:8j].
REQ-013 m_data  out  8  result byte stream data.
REQ-014 m_valid  out  1  m_data valid.
REQ-015 m_ready  in  1  downstream accepts m_data.
REQ-016 m_last  out  1  high with final result byte of a frame.
REQ-017 busy  out  1  high in any state other than LOAD.
REQ-018 timeout_err  out  1  sticky flag, last frame aborted by timeout.

Function
REQ-019 FSM states SHALL be LOAD, START, WAIT, UNLOAD.
REQ-020 LOAD: s_ready=1; each s_valid&s_ready beat writes s_data into nn_in byte idx, idx increments from 0.
REQ-021 LOAD -> START on the beat with idx==N_IN-1; idx returns to 0.
REQ-022 START: nn_start=1 for exactly one cycle, s_ready=0; next state WAIT unconditionally.
REQ-023 WAIT: wait counter increments each cycle from 0; nn_done ignored outside WAIT.
REQ-024 WAIT with nn_done=1: capture nn_out into result register on that edge, go UNLOAD, counter cleared.
REQ-025 WAIT with nn_done=0 and counter==TIMEOUT-1: set timeout_err, go LOAD, no result bytes emitted.
REQ-026 nn_done=1 in the same cycle as counter==TIMEOUT-1: done wins, no timeout.
REQ-027 UNLOAD: m_valid=1, m_data = captured byte j (j from 0), m_last=1 iff j==N_OUT-1.
REQ-028 m_data, m_last SHALL hold stable while m_valid&!m_ready.
REQ-029 Each m_valid&m_ready beat increments j; beat with j==N_OUT-1 returns to LOAD, j=0.
REQ-030 s_ready SHALL be 0 in START, WAIT, UNLOAD; input beats there are not consumed.
REQ-031 nn_in SHALL hold the frame during START/WAIT/UNLOAD and change only on accepted LOAD beats.
REQ-032 timeout_err SHALL clear on the first accepted byte of the next frame.
REQ-033 Counters sized to hold N_IN-1, N_OUT-1, TIMEOUT-1 without wrap; no other overflow path.
REQ-034 Registered outputs only except s_ready, m_valid, m_data, m_last, busy, which decode state/registers (no combinational input->output path).

Reset
REQ-035 rst_n low SHALL asynchronously force: state LOAD, idx=0, j=0, wait counter 0, nn_in=0, result register 0, nn_start=0, timeout_err=0; hence s_ready=1, m_valid=0, m_last=0, busy=0.
REQ-036 Reset asserted mid-frame (any state) SHALL discard partial input and uncaptured/unsent results; no nn_start or m_valid after release until a full new frame is loaded.

Verification
REQ-037 N_IN=1,N_OUT=1: send 0x5A, nn_done high 3 cycles after nn_start -> nn_in=0x5A, nn_start single pulse, one beat m_data=nn_out byte, m_last=1, then s_ready=1.
REQ-038 N_IN=4,N_OUT=2: bytes 0x01,0x02,0x03,0x04 with s_valid gaps -> nn_in=0x04030201, nn_start only after 4th beat; results 0xBBAA sent as 0xAA then 0xBB(m_last=1).
REQ-039 m_ready low 5 cycles during UNLOAD -> m_valid held, m_data unchanged, no byte skipped or duplicated.
REQ-040 TIMEOUT=8, nn_done never asserted -> timeout_err=1 exactly 8 cycles after entering WAIT, no m_valid, s_ready=1; next accepted byte clears timeout_err.
REQ-041 TIMEOUT=8, nn_done=1 on 8th WAIT cycle -> result captured, timeout_err stays 0.
REQ-042 rst_n pulsed low in WAIT and in UNLOAD -> all outputs at REQ-035 values immediately; fresh frame after release completes normally.
